// File: rtl/log2_fixed_point_pkg.sv
// Shared constants and helpers for the log2 fixed-point datapath
// (used by the CLZ front end and the normalizer).
package log2_fixed_point_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 8;

    // Ceiling log2 that can be evaluated at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int NORM_STAGES = clog2(DATA_W_DEF);

endpackage

// File: rtl/clz_norm_stage.sv
// One registered stage of the normalizing log-shifter: shifts left by SHIFT
// when the matching clz bit is set, and remembers any ones pushed off the top.
module clz_norm_stage
    import log2_fixed_point_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SHIFT  = 1
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              enb,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_word,
    input  logic [CNT_W-1:0]  i_clz,
    input  logic              i_lost,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_word,
    output logic [CNT_W-1:0]  o_clz,
    output logic              o_lost
);

    localparam int BIT = clog2(SHIFT);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] word_d,  word_q;
    logic [CNT_W-1:0]  clz_d,   clz_q;
    logic              lost_d,  lost_q;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
        valid_d = i_valid;
        word_d  = i_word;
        clz_d   = i_clz;
        lost_d  = i_lost;
        if (i_clz[BIT]) begin
            word_d = i_word << SHIFT;
            lost_d = i_lost | (|i_word[DATA_W-1 -: SHIFT]);
        end
    end

    always_ff @(posedge i_CLK) begin
        // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
        if (i_RST) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            clz_q   <= '0;
            lost_q  <= 1'b0;
        end else if (enb) begin
            valid_q <= valid_d;
            word_q  <= word_d;
            clz_q   <= clz_d;
            lost_q  <= lost_d;
        end
    end

    assign o_valid = valid_q;
    assign o_word  = word_q;
    assign o_clz   = clz_q;
    assign o_lost  = lost_q;

endmodule

// File: rtl/clz_normalize.sv
// Normalizes a word by its leading-zero count through a pipelined log-shifter,
// producing mantissa, exponent, zero, sticky and a clz consistency error.
module clz_normalize
    import log2_fixed_point_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int OUT_W  = 32
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              enb,
    input  logic              i_VALID,
    input  logic [CNT_W-1:0]  i_CLZ,
    input  logic [DATA_W-1:0] i_DATA,
    output logic              o_VALID,
    output logic [OUT_W-1:0]  o_MANT,
    output logic [CNT_W-1:0]  o_EXP,
    output logic              o_ZERO,
    output logic              o_STICKY,
    output logic              o_ERR
);

    localparam int STAGES = clog2(DATA_W);

    // Pipeline chain: index 0 is the input register, index STAGES the last shift stage.
    logic              valid_s [0:STAGES];
    logic [DATA_W-1:0] word_s  [0:STAGES];
    logic [CNT_W-1:0]  clz_s   [0:STAGES];
    logic              lost_s  [0:STAGES];

    // ---------------- input register ----------------
    logic              in_valid_d, in_valid_q;
    logic [DATA_W-1:0] in_word_d,  in_word_q;
    logic [CNT_W-1:0]  in_clz_d,   in_clz_q;
    logic              in_lost_d,  in_lost_q;
    logic              in_zero;

    assign in_zero = |i_CLZ[CNT_W-1:STAGES];

    always_comb begin
        in_valid_d = i_VALID;
        in_clz_d   = i_CLZ;
        in_word_d  = i_DATA;
        in_lost_d  = 1'b0;
        // A zero claim flushes the word; any set bit means the claim was wrong.
        if (in_zero) begin
            in_word_d = '0;
            in_lost_d = |i_DATA;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            in_valid_q <= 1'b0;
            in_word_q  <= '0;
            in_clz_q   <= '0;
            in_lost_q  <= 1'b0;
        end else if (enb) begin
            in_valid_q <= in_valid_d;
            in_word_q  <= in_word_d;
            in_clz_q   <= in_clz_d;
            in_lost_q  <= in_lost_d;
        end
    end

    assign valid_s[0] = in_valid_q;
    assign word_s[0]  = in_word_q;
    assign clz_s[0]   = in_clz_q;
    assign lost_s[0]  = in_lost_q;

    // ---------------- shift stages, largest shift first ----------------
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        clz_norm_stage #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W),
            .SHIFT  (1 << (STAGES - 1 - g))
        ) u_stage (
            .i_CLK   (i_CLK),
            .i_RST   (i_RST),
            .enb     (enb),
            .i_valid (valid_s[g]),
            .i_word  (word_s[g]),
            .i_clz   (clz_s[g]),
            .i_lost  (lost_s[g]),
            .o_valid (valid_s[g+1]),
            .o_word  (word_s[g+1]),
            .o_clz   (clz_s[g+1]),
            .o_lost  (lost_s[g+1])
        );
    end

    // ---------------- output register ----------------
    logic [DATA_W-1:0] fin_word;
    logic [CNT_W-1:0]  fin_clz;
    logic              fin_zero;
    logic              fin_sticky;

    assign fin_word = word_s[STAGES];
    assign fin_clz  = clz_s[STAGES];
    assign fin_zero = |fin_clz[CNT_W-1:STAGES];

    if (OUT_W < DATA_W) begin : g_sticky
        assign fin_sticky = |fin_word[DATA_W-OUT_W-1:0];
    end else begin : g_no_sticky
        assign fin_sticky = 1'b0;
    end

    logic              valid_d,  valid_q;
    logic [OUT_W-1:0]  mant_d,   mant_q;
    logic [CNT_W-1:0]  exp_d,    exp_q;
    logic              zero_d,   zero_q;
    logic              sticky_d, sticky_q;
    logic              err_d,    err_q;

    always_comb begin
        valid_d  = valid_s[STAGES];
        mant_d   = fin_word[DATA_W-1 -: OUT_W];
        zero_d   = fin_zero;
        sticky_d = fin_sticky;
        exp_d    = '0;
        if (!fin_zero) begin
            exp_d = CNT_W'(DATA_W - 1) - fin_clz;
        end
        // Lost bits mean clz was too large; a clear MSB means it was too small.
        err_d = lost_s[STAGES] | (!fin_zero & !fin_word[DATA_W-1]);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            valid_q  <= 1'b0;
            mant_q   <= '0;
            exp_q    <= '0;
            zero_q   <= 1'b0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (enb) begin
            valid_q  <= valid_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            zero_q   <= zero_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
        end
    end

    assign o_VALID  = valid_q;
    assign o_MANT   = mant_q;
    assign o_EXP    = exp_q;
    assign o_ZERO   = zero_q;
    assign o_STICKY = sticky_q;
    assign o_ERR    = err_q;

endmodule

// File: tb/tb_clz_normalize.sv
// Directed bench for clz_normalize at default parameters (latency 9 enabled cycles).
module tb_clz_normalize;

    logic         i_CLK;
    logic         i_RST;
    logic         enb;
    logic         i_VALID;
    logic [7:0]   i_CLZ;
    logic [127:0] i_DATA;
    logic         o_VALID;
    logic [31:0]  o_MANT;
    logic [7:0]   o_EXP;
    logic         o_ZERO;
    logic         o_STICKY;
    logic         o_ERR;

    int checks;
    int failures;

    clz_normalize dut (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .enb      (enb),
        .i_VALID  (i_VALID),
        .i_CLZ    (i_CLZ),
        .i_DATA   (i_DATA),
        .o_VALID  (o_VALID),
        .o_MANT   (o_MANT),
        .o_EXP    (o_EXP),
        .o_ZERO   (o_ZERO),
        .o_STICKY (o_STICKY),
        .o_ERR    (o_ERR)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] mant,
                             input logic [7:0] exp, input logic zero, input logic sticky,
                             input logic err);
        check({tag, ".valid"},  64'(o_VALID),  64'(v));
        check({tag, ".mant"},   64'(o_MANT),   64'(mant));
        check({tag, ".exp"},    64'(o_EXP),    64'(exp));
        check({tag, ".zero"},   64'(o_ZERO),   64'(zero));
        check({tag, ".sticky"}, 64'(o_STICKY), 64'(sticky));
        check({tag, ".err"},    64'(o_ERR),    64'(err));
    endtask

    // Drive one sample at a falling edge, then land on the falling edge after its 9th rising edge.
    task automatic send_and_wait(input logic [7:0] clz, input logic [127:0] data);
        @(negedge i_CLK);
        i_VALID = 1'b1;
        i_CLZ   = clz;
        i_DATA  = data;
        @(negedge i_CLK);
        i_VALID = 1'b0;
        i_CLZ   = 8'd0;
        i_DATA  = '0;
        repeat (8) @(negedge i_CLK);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        i_RST    = 1'b1;
        enb      = 1'b1;
        i_VALID  = 1'b0;
        i_CLZ    = 8'd0;
        i_DATA   = '0;
        repeat (3) @(negedge i_CLK);
        check_out("reset", 1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        i_RST = 1'b0;

        send_and_wait(8'd127, 128'd1);
        check_out("one", 1'b1, 32'h8000_0000, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge i_CLK);
        check("one.valid_drop", 64'(o_VALID), 64'(0));

        send_and_wait(8'd0, {1'b1, 126'd0, 1'b1});
        check_out("msb_sticky", 1'b1, 32'h8000_0000, 8'd127, 1'b0, 1'b1, 1'b0);

        send_and_wait(8'd111, (128'd1 << 16) | 128'd1);
        check_out("bits16_0", 1'b1, 32'h8000_8000, 8'd16, 1'b0, 1'b0, 1'b0);

        send_and_wait(8'd128, 128'd0);
        check_out("zero", 1'b1, 32'h0, 8'd0, 1'b1, 1'b0, 1'b0);

        send_and_wait(8'd128, 128'd5);
        check_out("zero_bad", 1'b1, 32'h0, 8'd0, 1'b1, 1'b0, 1'b1);

        send_and_wait(8'd126, 128'd1);
        check_out("clz_small", 1'b1, 32'h4000_0000, 8'd1, 1'b0, 1'b0, 1'b1);

        send_and_wait(8'd127, 128'd3);
        check_out("clz_big", 1'b1, 32'h8000_0000, 8'd0, 1'b0, 1'b0, 1'b1);

        // Back-to-back samples with a 2-cycle stall after the second.
        @(negedge i_CLK);
        i_VALID = 1'b1; i_CLZ = 8'd63; i_DATA = 128'd1 << 64;
        @(negedge i_CLK);
        i_CLZ = 8'd24; i_DATA = 128'hF << 100;
        @(negedge i_CLK);
        enb = 1'b0;
        i_CLZ = 8'd99; i_DATA = 128'h1234_5678;
        repeat (2) @(negedge i_CLK);
        enb = 1'b1;
        @(negedge i_CLK);
        i_VALID = 1'b0; i_CLZ = 8'd0; i_DATA = '0;
        repeat (6) @(negedge i_CLK);
        check_out("b2b_a", 1'b1, 32'h8000_0000, 8'd64, 1'b0, 1'b0, 1'b0);
        enb = 1'b0;
        @(negedge i_CLK);
        check_out("hold1", 1'b1, 32'h8000_0000, 8'd64, 1'b0, 1'b0, 1'b0);
        @(negedge i_CLK);
        check_out("hold2", 1'b1, 32'h8000_0000, 8'd64, 1'b0, 1'b0, 1'b0);
        enb = 1'b1;
        @(negedge i_CLK);
        check_out("b2b_b", 1'b1, 32'hF000_0000, 8'd103, 1'b0, 1'b0, 1'b0);
        @(negedge i_CLK);
        check_out("b2b_c", 1'b1, 32'h91A2_B3C0, 8'd28, 1'b0, 1'b0, 1'b0);
        @(negedge i_CLK);
        check("b2b.valid_drop", 64'(o_VALID), 64'(0));

        // Reset with three samples in flight flushes them all.
        @(negedge i_CLK);
        i_VALID = 1'b1; i_CLZ = 8'd127; i_DATA = 128'd1;
        @(negedge i_CLK);
        i_CLZ = 8'd0; i_DATA = {1'b1, 127'd0};
        @(negedge i_CLK);
        i_CLZ = 8'd126; i_DATA = 128'd3;
        @(negedge i_CLK);
        i_VALID = 1'b0; i_CLZ = 8'd0; i_DATA = '0;
        i_RST = 1'b1;
        @(negedge i_CLK);
        i_RST = 1'b0;
        check_out("flush", 1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        begin
            int seen_valid;
            seen_valid = 0;
            repeat (12) begin
                @(negedge i_CLK);
                if (o_VALID) seen_valid++;
            end
            check("flush.no_valid", 64'(seen_valid), 64'(0));
        end

        send_and_wait(8'd124, 128'd9);
        check_out("after_flush", 1'b1, 32'h9000_0000, 8'd3, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
